// File: rtl/ysyx_22040386_pkg.sv
// Shared constants for the writeback path: source indices and default widths
// of the GPR write port.
package ysyx_22040386_pkg;

    localparam int WB_SRC_PIPE = 0;
    localparam int WB_SRC_LSU  = 1;
    localparam int WB_SRC_MDU  = 2;
    localparam int NUM_WB_SRC  = 3;

    localparam int WB_DATA_W = 64;
    localparam int WB_ADDR_W = 5;

endpackage

// File: rtl/ysyx_22040386_rr_pick.sv
// Rotate-priority picker: grants the first valid requester at or after ptr,
// scanning upward modulo N. Purely combinational; ptr must be below N.
module ysyx_22040386_rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    logic [PTR_W:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            if (!any && valid[pos[PTR_W-1:0]]) begin
                grant[pos[PTR_W-1:0]] = 1'b1;
                idx                   = pos[PTR_W-1:0];
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22040386_wb_arbiter.sv
// Round-robin arbiter sharing the single GPR write port between the pipeline
// WB stage, the LSU load return and the MDU; the winning write is registered.
module ysyx_22040386_wb_arbiter
    import ysyx_22040386_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_SRC,
    parameter int DATA_W  = WB_DATA_W,
    parameter int ADDR_W  = WB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_hold,
    output logic                       o_reg_wr_en,
    output logic [ADDR_W-1:0]          o_reg_wr_addr,
    output logic [DATA_W-1:0]          o_reg_wr_data,
    output logic                       o_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [ADDR_W-1:0] req_addr [NUM_REQ];
    logic [DATA_W-1:0] req_data [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr[gi] = i_req_addr[gi*ADDR_W +: ADDR_W];
            assign req_data[gi] = i_req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [NUM_REQ-1:0] pick_valid;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic               xfer;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    // Hold and reset both mask the request vector, so no grant can leak out.
    assign pick_valid = (i_hold || rst) ? '0 : i_req_valid;

    ysyx_22040386_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid (pick_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (xfer)
    );

    assign o_req_ready = grant;
    assign win_addr    = req_addr[win_idx];
    assign win_data    = req_data[win_idx];
    assign o_busy      = (|i_req_valid) || o_reg_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            o_reg_wr_en   <= 1'b0;
            o_reg_wr_addr <= '0;
            o_reg_wr_data <= '0;
        end else begin
            o_reg_wr_en <= 1'b0;
            if (xfer) begin
                rr_ptr        <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                // x0 writes are consumed but never reach the register file.
                o_reg_wr_en   <= (win_addr != '0);
                o_reg_wr_addr <= win_addr;
                o_reg_wr_data <= win_data;
            end
        end
    end

endmodule
